// File: rtl/bitscan_encoder_pkg.sv
// Shared types for the bit-scan encoder and its find-first-set helper.
package bitscan_encoder_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/bitscan_encoder_prio_ffs.sv
// Combinational find-first-set starting at a rotating pointer, wrapping mod N.
module prio_ffs #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         any
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int unsigned pos_v;
    logic [W-1:0] pos_w;
    idx    = '0;
    onehot = '0;
    any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      pos_v = int'(ptr) + i;
      if (pos_v >= N) begin
        pos_v = pos_v - N;
      end else begin
        pos_v = pos_v;
      end
      pos_w = W'(pos_v);
      if (req[pos_w]) begin
        idx           = pos_w;
        onehot        = '0;
        onehot[pos_w] = 1'b1;
        any           = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/bitscan_encoder.sv
// Priority encoder: accepts a request vector and streams the index of every set
// bit, one per cycle, fixed-priority or round-robin from a rotating start pointer.
module bitscan_encoder
  import bitscan_encoder_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int RR = 0,
  localparam int W  = $clog2(N)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic [N-1:0] in_vec,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_last,
  output logic         out_none
);

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         none_nxt_s;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic [N-1:0] out_onehot_q, out_onehot_d;
  logic         out_last_q, out_last_d;
  logic         out_none_q, out_none_d;

  logic         fire_s;
  logic         accept_s;
  logic [W-1:0] ffs_idx_s;
  logic [N-1:0] ffs_onehot_s;
  logic         ffs_any_s;

  // The scan runs on the next-cycle pending set so the output registers
  // already hold the index that will be showing after this edge.
  prio_ffs #(.N(N)) u_ffs (
    .req    (pend_d),
    .ptr    (ptr_d),
    .idx    (ffs_idx_s),
    .onehot (ffs_onehot_s),
    .any    (ffs_any_s)
  );

  assign fire_s   = out_valid_q & out_ready;
  assign in_ready = (state_q == ST_IDLE) | (fire_s & out_last_q);
  assign accept_s = in_valid & in_ready;

  // FSM, pending set and round-robin pointer next-state.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    ptr_d      = ptr_q;
    none_nxt_s = out_none_q;
    if (flush) begin
      state_d    = ST_IDLE;
      pend_d     = '0;
      none_nxt_s = 1'b0;
    end else begin
      if (fire_s) begin
        pend_d = pend_q & ~out_onehot_q;
        if (out_last_q) begin
          state_d    = ST_IDLE;
          none_nxt_s = 1'b0;
          if ((RR != 0) && !out_none_q) begin
            if (out_idx_q == W'(N - 1)) begin
              ptr_d = '0;
            end else begin
              ptr_d = out_idx_q + W'(1);
            end
          end else begin
            ptr_d = ptr_q;
          end
        end else begin
          state_d = ST_SCAN;
        end
      end else begin
        pend_d = pend_q;
      end
      if (accept_s) begin
        pend_d     = in_vec;
        none_nxt_s = (in_vec == '0);
        state_d    = ST_SCAN;
      end else begin
        state_d = state_d;
      end
    end
  end

  // Output field next-state; all fields read zero whenever the block idles.
  always_comb begin
    out_valid_d  = 1'b0;
    out_idx_d    = '0;
    out_onehot_d = '0;
    out_last_d   = 1'b0;
    out_none_d   = 1'b0;
    case (state_d)
      ST_SCAN: begin
        out_valid_d  = 1'b1;
        out_idx_d    = ffs_idx_s;
        out_onehot_d = ffs_any_s ? ffs_onehot_s : '0;
        out_last_d   = ((pend_d & (pend_d - N'(1))) == '0);
        out_none_d   = none_nxt_s;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
      out_last_q   <= 1'b0;
      out_none_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      out_last_q   <= out_last_d;
      out_none_q   <= out_none_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_onehot = out_onehot_q;
  assign out_last   = out_last_q;
  assign out_none   = out_none_q;

endmodule

// File: tb/tb_bitscan_encoder.sv
// Randomised bench for bitscan_encoder: fixed-priority and round-robin instances
// share one input stream and are each checked against an index-list model.
module tb_bitscan_encoder;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_vec = 8'h00;

  logic       in_ready_s   [2];
  logic       out_valid_s  [2];
  logic       out_last_s   [2];
  logic       out_none_s   [2];
  logic [2:0] out_idx_s    [2];
  logic [7:0] out_onehot_s [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Model: the remaining indices of the current vector, in emission order.
  bit busy_m [2];
  int lst_m  [2][8];
  int len_m  [2];
  int pos_m  [2];
  int ptr_m  [2];
  bit none_m [2];

  always #5 clk = ~clk;

  bitscan_encoder #(.N(N), .RR(0)) u_dut_fp (
    .clk(clk), .resetn(resetn), .flush(flush), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready),
    .out_idx(out_idx_s[0]), .out_onehot(out_onehot_s[0]), .out_last(out_last_s[0]),
    .out_none(out_none_s[0])
  );

  bitscan_encoder #(.N(N), .RR(1)) u_dut_rr (
    .clk(clk), .resetn(resetn), .flush(flush), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready),
    .out_idx(out_idx_s[1]), .out_onehot(out_onehot_s[1]), .out_last(out_last_s[1]),
    .out_none(out_none_s[1])
  );

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      busy_m[d] = 1'b0; len_m[d] = 0; pos_m[d] = 0; ptr_m[d] = 0; none_m[d] = 1'b0;
    end
  endfunction

  function automatic void model_load(input int d, input logic [7:0] vec);
    int b;
    len_m[d] = 0;
    pos_m[d] = 0;
    for (int i = 0; i < N; i++) begin
      b = (ptr_m[d] + i) % N;
      if (vec[b]) begin
        lst_m[d][len_m[d]] = b;
        len_m[d]++;
      end
    end
    none_m[d] = (len_m[d] == 0);
    busy_m[d] = 1'b1;
  endfunction

  function automatic int exp_idx(input int d);
    return none_m[d] ? 0 : lst_m[d][pos_m[d]];
  endfunction

  function automatic bit exp_last(input int d);
    return (len_m[d] - pos_m[d]) <= 1;
  endfunction

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("out_valid[%0d]", d), out_valid_s[d], busy_m[d]);
      if (busy_m[d]) begin
        check_eq($sformatf("out_idx[%0d]", d), out_idx_s[d], exp_idx(d));
        check_eq($sformatf("out_onehot[%0d]", d), out_onehot_s[d],
                 none_m[d] ? 0 : (32'd1 << exp_idx(d)));
        check_eq($sformatf("out_last[%0d]", d), out_last_s[d], exp_last(d));
        check_eq($sformatf("out_none[%0d]", d), out_none_s[d], none_m[d]);
      end
    end
  endtask

  // One cycle: drive inputs at the falling edge, check in_ready, advance the
  // model across the rising edge, then check outputs at the next falling edge.
  task automatic step(input logic iv, input logic [7:0] vec, input logic ordy, input logic fl);
    bit rdy;
    int idx;
    in_valid = iv; in_vec = vec; out_ready = ordy; flush = fl;
    #1;
    for (int d = 0; d < 2; d++) begin
      rdy = !busy_m[d] || (ordy && exp_last(d));
      check_eq($sformatf("in_ready[%0d]", d), in_ready_s[d], rdy);
      if (fl) begin
        busy_m[d] = 1'b0; none_m[d] = 1'b0; len_m[d] = 0; pos_m[d] = 0;
      end else begin
        if (busy_m[d] && ordy) begin
          idx = exp_idx(d);
          if (exp_last(d)) begin
            busy_m[d] = 1'b0;
            if (d == 1 && !none_m[d]) ptr_m[d] = (idx + 1) % N;
          end
          pos_m[d]++;
        end
        if (iv && rdy) model_load(d, vec);
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset mid-cycle; outputs must return to reset values at once.
  task automatic apply_reset();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 resetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst_valid[%0d]", d), out_valid_s[d], 0);
      check_eq($sformatf("rst_idx[%0d]", d), out_idx_s[d], 0);
      check_eq($sformatf("rst_onehot[%0d]", d), out_onehot_s[d], 0);
      check_eq($sformatf("rst_last[%0d]", d), out_last_s[d], 0);
      check_eq($sformatf("rst_none[%0d]", d), out_none_s[d], 0);
      check_eq($sformatf("rst_ready[%0d]", d), in_ready_s[d], 1);
    end
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    model_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("init_valid[%0d]", d), out_valid_s[d], 0);
      check_eq($sformatf("init_ready[%0d]", d), in_ready_s[d], 1);
    end
    resetn = 1'b1;

    // Fixed-priority sequence, back-to-back zero vector on the last beat.
    step(1'b1, 8'hA4, 1'b1, 1'b0);
    check_eq("t2_idx_first", out_idx_s[0], 2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("t2_idx_last", out_idx_s[0], 7);
    check_eq("t2_last", out_last_s[0], 1);
    step(1'b1, 8'h00, 1'b1, 1'b0);
    check_eq("t3_none", out_none_s[0], 1);
    check_eq("t3_onehot", out_onehot_s[0], 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure holds the first index; in_vec changes are ignored meanwhile.
    step(1'b1, 8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 1'b0, 1'b0);
    check_eq("t4_hold_idx", out_idx_s[0], 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("t4_idx_second", out_idx_s[0], 4);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Round-robin pointer advance.
    apply_reset();
    step(1'b1, 8'h05, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("t5_rr_idx2", out_idx_s[1], 2);
    step(1'b1, 8'h89, 1'b1, 1'b0);
    check_eq("t5_rr_idx3", out_idx_s[1], 3);
    check_eq("t5_fp_idx0", out_idx_s[0], 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("t5_rr_wrap", out_idx_s[1], 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with index 6 showing; pointer survives.
    step(1'b1, 8'hC0, 1'b0, 1'b0);
    check_eq("t6_rr_idx6", out_idx_s[1], 6);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("t6_flush_valid", out_valid_s[1], 0);
    step(1'b1, 8'h01, 1'b1, 1'b0);
    check_eq("t6_after_flush", out_idx_s[1], 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h06, 1'b1, 1'b0);
    check_eq("t6_rr_ptr1", out_idx_s[1], 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step(1'($urandom_range(0, 3) != 0), v, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0));
    end

    // Reset in the middle of a scan.
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    apply_reset();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h30, 1'b1, 1'b0);
    check_eq("post_rst_idx", out_idx_s[1], 4);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
